// File: rtl/microwave_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_ctrl
//   Microwave oven control FSM. It consumes one-cycle button pulses and the
//   door switch level. It drives the magnetron, the lamp, the beeper and the
//   seconds countdown for the display. A one-second tick is derived
//   internally from the system clock; it only runs while cooking or beeping.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   add_min_p     one-cycle pulse: add 60 s
//   add_10s_p     one-cycle pulse: add 10 s
//   start_p       one-cycle pulse: start or resume
//   stop_p        one-cycle pulse: pause, or clear and cancel
//   door_open     synchronized level, 1 = door open
//   time_left     remaining seconds, 0..MAX_SEC
//   state         IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
//   magnetron_on  high while cooking
//   lamp_on       high while cooking or while the door is open (combinational)
//   beep          high while in DONE
// -----------------------------------------------------------------------------
module microwave_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int MAX_SEC   = 5999,
  parameter int BEEP_SEC  = 3,
  parameter int QUICK_SEC = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_min_p,
  input  logic        add_10s_p,
  input  logic        start_p,
  input  logic        stop_p,
  input  logic        door_open,
  output logic [12:0] time_left,
  output logic [2:0]  state,
  output logic        magnetron_on,
  output logic        lamp_on,
  output logic        beep
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);
  localparam logic [12:0]       TIME_MAX  = 13'(MAX_SEC);
  localparam logic [12:0]       TIME_QCK  = 13'(QUICK_SEC);

  state_t              state_q, state_d;
  logic [12:0]         time_d;
  logic [12:0]         cook_t;
  logic [TICK_W-1:0]   tick_cnt, tick_d;
  logic [BEEP_W-1:0]   beep_cnt, beep_cnt_d;
  logic                timed;
  logic                tick;
  logic                add_any;
  logic [6:0]          add_amt;

  // Exact saturation at MAX_SEC; the extra sum bit rules out any wrap.
  function automatic logic [12:0] sat_add(input logic [12:0] t, input logic [6:0] n);
    logic [13:0] sum;
    logic [12:0] res;
    sum = {1'b0, t} + {7'd0, n};
    if (sum > {1'b0, TIME_MAX}) res = TIME_MAX;
    else                        res = sum[12:0];
    return res;
  endfunction

  assign timed   = (state_q == S_COOK) || (state_q == S_DONE);
  assign tick    = timed && (tick_cnt == TICK_LAST);
  assign add_any = add_min_p || add_10s_p;
  assign add_amt = add_min_p ? 7'd60 : 7'd10;

  // ---- next-state / next-time stage ----
  always_comb begin
    state_d    = state_q;
    time_d     = time_left;
    cook_t     = time_left;
    beep_cnt_d = beep_cnt;
    tick_d     = (timed && !tick) ? tick_cnt + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        // stop_p outranks everything and does nothing here.
        if (!stop_p) begin
          if (start_p) begin
            if (!door_open) begin
              state_d = S_COOK;
              time_d  = TIME_QCK;
            end
          end else if (add_any) begin
            state_d = S_SET;
            time_d  = sat_add(13'd0, add_amt);
          end
        end
      end
      S_SET, S_PAUSE: begin
        if (stop_p) begin
          state_d = S_IDLE;
          time_d  = 13'd0;
        end else if (start_p) begin
          if (!door_open) state_d = S_COOK;
        end else if (add_any) begin
          time_d = sat_add(time_left, add_amt);
        end
      end
      S_COOK: begin
        if (stop_p || door_open) begin
          state_d = S_PAUSE;
        end else begin
          // start_p outranks the adds, so an add paired with start is dropped.
          if (!start_p && add_any) cook_t = sat_add(time_left, add_amt);
          if (tick) begin
            if (cook_t <= 13'd1) begin
              time_d  = 13'd0;
              state_d = S_DONE;
            end else begin
              time_d = cook_t - 13'd1;
            end
          end else begin
            time_d = cook_t;
          end
        end
      end
      S_DONE: begin
        time_d = 13'd0;
        if (stop_p || door_open) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (beep_cnt == BEEP_LAST) state_d = S_IDLE;
          else                       beep_cnt_d = beep_cnt + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every state change restarts the second and the beep count, so a
    // partial second is dropped on pause and a fresh COOK/DONE starts at 0.
    if (state_d != state_q) begin
      tick_d     = '0;
      beep_cnt_d = '0;
    end
  end

  // ---- registered stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      time_left <= 13'd0;
      tick_cnt  <= '0;
      beep_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      time_left <= time_d;
      tick_cnt  <= tick_d;
      beep_cnt  <= beep_cnt_d;
    end
  end

  assign state        = state_q;
  assign magnetron_on = (state_q == S_COOK);
  assign beep         = (state_q == S_DONE);
  assign lamp_on      = (state_q == S_COOK) || door_open;

endmodule

// File: tb/tb_microwave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_ctrl
//   Directed bench for microwave_ctrl with CLK_HZ=10, BEEP_SEC=3. A
//   behavioural model tracks the oven in seconds and sub-second cycles and is
//   compared with the DUT on every falling edge. Literal expectations are
//   placed along each scenario as well.
// -----------------------------------------------------------------------------
module tb_microwave_ctrl;

  localparam int CLK_HZ    = 10;
  localparam int MAX_SEC   = 5999;
  localparam int BEEP_SEC  = 3;
  localparam int QUICK_SEC = 30;

  localparam int IDLE = 0, SET = 1, COOK = 2, PAUSE = 3, DONE = 4;
  localparam int B_MIN = 0, B_10S = 1, B_START = 2, B_STOP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        add_min_p = 1'b0;
  logic        add_10s_p = 1'b0;
  logic        start_p   = 1'b0;
  logic        stop_p    = 1'b0;
  logic        door_open = 1'b0;
  logic [12:0] time_left;
  logic [2:0]  state;
  logic        magnetron_on;
  logic        lamp_on;
  logic        beep;

  int checks = 0;
  int errors = 0;

  microwave_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .MAX_SEC  (MAX_SEC),
    .BEEP_SEC (BEEP_SEC),
    .QUICK_SEC(QUICK_SEC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_min_p   (add_min_p),
    .add_10s_p   (add_10s_p),
    .start_p     (start_p),
    .stop_p      (stop_p),
    .door_open   (door_open),
    .time_left   (time_left),
    .state       (state),
    .magnetron_on(magnetron_on),
    .lamp_on     (lamp_on),
    .beep        (beep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = IDLE;
  int m_time  = 0;
  int m_sub   = 0;   // cycles elapsed in the current second
  int m_beeps = 0;   // whole seconds spent beeping

  function automatic int sat(input int v);
    return (v > MAX_SEC) ? MAX_SEC : v;
  endfunction

  task automatic model_step(output int nst, output int ntm, output int nsub, output int nbp);
    int  add;
    bit  running;
    bit  second;
    add     = add_min_p ? 60 : (add_10s_p ? 10 : 0);
    running = (m_state == COOK) || (m_state == DONE);
    second  = running && (m_sub == CLK_HZ - 1);
    nst  = m_state;
    ntm  = m_time;
    nbp  = m_beeps;
    nsub = (running && !second) ? m_sub + 1 : 0;
    if (m_state == IDLE) begin
      if (stop_p) ;
      else if (start_p) begin
        if (!door_open) begin nst = COOK; ntm = QUICK_SEC; end
      end else if (add != 0) begin
        nst = SET; ntm = sat(add);
      end
    end else if (m_state == SET || m_state == PAUSE) begin
      if (stop_p) begin nst = IDLE; ntm = 0; end
      else if (start_p) begin
        if (!door_open) nst = COOK;
      end else if (add != 0) ntm = sat(m_time + add);
    end else if (m_state == COOK) begin
      if (stop_p || door_open) nst = PAUSE;
      else begin
        if (!start_p && add != 0) ntm = sat(m_time + add);
        if (second) begin
          ntm = ntm - 1;
          if (ntm <= 0) begin ntm = 0; nst = DONE; end
        end
      end
    end else if (m_state == DONE) begin
      ntm = 0;
      if (stop_p || door_open) nst = IDLE;
      else if (second) begin
        nbp = m_beeps + 1;
        if (nbp == BEEP_SEC) nst = IDLE;
      end
    end else begin
      nst = IDLE;
    end
    if (nst != m_state) begin nsub = 0; nbp = 0; end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int nst, ntm, nsub, nbp;
    if (!rst_n) begin
      m_state <= IDLE;
      m_time  <= 0;
      m_sub   <= 0;
      m_beeps <= 0;
    end else begin
      model_step(nst, ntm, nsub, nbp);
      m_state <= nst;
      m_time  <= ntm;
      m_sub   <= nsub;
      m_beeps <= nbp;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_state",     32'(state),        32'(m_state));
    check("model_time_left", 32'(time_left),    32'(m_time));
    check("model_magnetron", 32'(magnetron_on), 32'(m_state == COOK));
    check("model_beep",      32'(beep),         32'(m_state == DONE));
    check("model_lamp",      32'(lamp_on),      32'((m_state == COOK) || door_open));
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input int which);
    case (which)
      B_MIN:   add_min_p = 1'b1;
      B_10S:   add_10s_p = 1'b1;
      B_START: start_p   = 1'b1;
      default: stop_p    = 1'b1;
    endcase
    cycles(1);
    add_min_p = 1'b0;
    add_10s_p = 1'b0;
    start_p   = 1'b0;
    stop_p    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_state",     32'(state),        32'(IDLE));
    check("rst_time",      32'(time_left),    32'd0);
    check("rst_magnetron", 32'(magnetron_on), 32'd0);
    check("rst_beep",      32'(beep),         32'd0);
    check("rst_lamp",      32'(lamp_on),      32'd0);
    rst_n = 1'b1;
    cycles(1);

    // Add then cook to completion.
    pulse(B_10S);
    check("s1_set_state", 32'(state), 32'(SET));
    check("s1_set_time",  32'(time_left), 32'd10);
    pulse(B_START);
    check("s1_cook_state", 32'(state), 32'(COOK));
    cycles(9);
    check("s1_pre_tick_time", 32'(time_left), 32'd10);
    cycles(1);
    check("s1_first_tick_time", 32'(time_left), 32'd9);
    cycles(89);
    check("s1_last_sec_state", 32'(state), 32'(COOK));
    check("s1_last_sec_time",  32'(time_left), 32'd1);
    cycles(1);
    check("s1_done_state", 32'(state), 32'(DONE));
    check("s1_done_beep",  32'(beep), 32'd1);
    check("s1_done_time",  32'(time_left), 32'd0);
    cycles(29);
    check("s1_still_done", 32'(state), 32'(DONE));
    cycles(1);
    check("s1_back_idle", 32'(state), 32'(IDLE));

    // Door during cook.
    pulse(B_10S);
    pulse(B_START);
    cycles(50);
    check("s2_cook_time5", 32'(time_left), 32'd5);
    door_open = 1'b1;
    cycles(1);
    check("s2_pause_state", 32'(state), 32'(PAUSE));
    check("s2_pause_mag",   32'(magnetron_on), 32'd0);
    check("s2_pause_lamp",  32'(lamp_on), 32'd1);
    check("s2_pause_time",  32'(time_left), 32'd5);
    pulse(B_START);
    check("s2_start_door_open", 32'(state), 32'(PAUSE));
    door_open = 1'b0;
    cycles(1);
    pulse(B_START);
    check("s2_resume_state", 32'(state), 32'(COOK));
    cycles(9);
    check("s2_resume_hold", 32'(time_left), 32'd5);
    cycles(1);
    check("s2_resume_tick", 32'(time_left), 32'd4);
    pulse(B_STOP);
    pulse(B_STOP);
    check("s2_cancel_state", 32'(state), 32'(IDLE));

    // Door opened while beeping ends DONE at once.
    pulse(B_10S);
    pulse(B_START);
    cycles(100);
    check("s2b_done", 32'(state), 32'(DONE));
    door_open = 1'b1;
    cycles(1);
    check("s2b_door_idle", 32'(state), 32'(IDLE));
    check("s2b_door_lamp", 32'(lamp_on), 32'd1);
    door_open = 1'b0;
    cycles(1);

    // Saturation.
    for (int i = 0; i < 99; i++) begin
      pulse(B_MIN);
      cycles(1);
    end
    check("s3_99min", 32'(time_left), 32'd5940);
    pulse(B_MIN);
    check("s3_sat_min", 32'(time_left), 32'd5999);
    pulse(B_10S);
    check("s3_sat_10s", 32'(time_left), 32'd5999);
    pulse(B_STOP);
    check("s3_clear_state", 32'(state), 32'(IDLE));
    check("s3_clear_time",  32'(time_left), 32'd0);

    // Same-cycle events.
    pulse(B_10S);
    stop_p  = 1'b1;
    start_p = 1'b1;
    cycles(1);
    stop_p  = 1'b0;
    start_p = 1'b0;
    check("s4_stop_start_state", 32'(state), 32'(IDLE));
    check("s4_stop_start_time",  32'(time_left), 32'd0);
    pulse(B_10S);
    pulse(B_START);
    cycles(30);
    check("s4_time7", 32'(time_left), 32'd7);
    cycles(9);
    pulse(B_10S);
    check("s4_add_on_tick", 32'(time_left), 32'd16);
    pulse(B_STOP);
    pulse(B_STOP);

    // Quick start and cancel.
    pulse(B_START);
    check("s5_quick_state", 32'(state), 32'(COOK));
    check("s5_quick_time",  32'(time_left), 32'd30);
    pulse(B_STOP);
    check("s5_pause_state", 32'(state), 32'(PAUSE));
    check("s5_pause_time",  32'(time_left), 32'd30);
    pulse(B_STOP);
    check("s5_idle_state", 32'(state), 32'(IDLE));
    check("s5_idle_time",  32'(time_left), 32'd0);

    // Asynchronous reset mid-cook.
    pulse(B_START);
    cycles(5);
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_state", 32'(state), 32'(IDLE));
    check("s6_async_time",  32'(time_left), 32'd0);
    check("s6_async_mag",   32'(magnetron_on), 32'd0);
    check("s6_async_beep",  32'(beep), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    check("s6_after_state", 32'(state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Microwave oven control FSM that consumes the single-cycle button pulses produced by the spot stages and the door switch level, and drives magnetron, lamp, beeper and a seconds countdown for the display. It sits directly downstream of one spot instance per button. All timekeeping is derived from the system clock by an internal one-second tick generator.

## Interface

Parameters:
- CLK_HZ, 100_000_000, clock cycles per second; the tick period. Benches set it to 10.
- MAX_SEC, 5999, cook-time saturation limit in seconds.
- BEEP_SEC, 3, seconds spent in DONE before the automatic return to IDLE.
- QUICK_SEC, 30, time loaded by start from IDLE with no time set.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- add_min_p  in  1  one-cycle pulse from spot; add 60 s.
- add_10s_p  in  1  one-cycle pulse from spot; add 10 s.
- start_p  in  1  one-cycle pulse from spot; start or resume.
- stop_p  in  1  one-cycle pulse from spot; pause, or clear and cancel.
- door_open  in  1  level, already synchronized; 1 = door open.
- time_left  out  13  remaining seconds, binary, 0..MAX_SEC.
- state  out  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
- magnetron_on  out  1  1 iff state==COOK.
- lamp_on  out  1  1 iff state==COOK or door_open.
- beep  out  1  1 iff state==DONE.

## Operation

- Registered state and time; on rst_n low: state=IDLE, time_left=0, tick counter=0, beep counter=0, magnetron_on=0, beep=0.
- lamp_on is combinational (COOK or door_open), so it follows door_open even during reset.
- Event priority per cycle, highest first: stop_p, door_open (COOK only), start_p, add_min_p, add_10s_p. Only the highest-priority event acts in a given cycle.
- Add arithmetic: time_left = min(time_left + 60 or 10, MAX_SEC). Saturation is exact and there is no wrap.
- IDLE:
  - add_* loads the added time and goes to SET.
  - start_p with door closed loads QUICK_SEC and goes to COOK.
  - start_p with door open is ignored.
  - stop_p has no effect.
- SET:
  - add_* accumulates.
  - start_p with door closed goes to COOK.
  - stop_p clears time_left to 0 and goes to IDLE.
- COOK:
  - stop_p or door_open goes to PAUSE, and time_left holds.
  - add_* accumulates.
  - On each tick, time_left decrements by 1.
  - If an add and a tick land in the same cycle, time_left = min(time_left + n, MAX_SEC) − 1.
  - A tick that takes time_left from 1 to 0 moves to DONE in the same update.
- PAUSE:
  - start_p with door closed goes to COOK.
  - stop_p clears time_left and goes to IDLE.
  - add_* accumulates.
- DONE:
  - time_left = 0.
  - The beep counter counts ticks; on reaching BEEP_SEC the block goes to IDLE.
  - stop_p or door_open goes to IDLE immediately.
  - start_p and add_* are ignored.
- Illegal state encodings (5–7) go to IDLE on the next clock.

## Timing

- Tick counter:
  - Counts 0..CLK_HZ−1 only in COOK and DONE.
  - Cleared on every entry into COOK or DONE.
  - A tick fires on the cycle the counter equals CLK_HZ−1.
  - The first decrement therefore occurs exactly CLK_HZ cycles after COOK entry.
  - The partial second is discarded on PAUSE.
- Input to output latency: pulse at cycle N means the state, time_left, magnetron_on and beep change is visible after the rising edge ending cycle N (1-cycle latency).
- Door: door_open asserted in COOK means magnetron_on=0 one cycle later, and lamp_on stays 1 throughout.
- Pulses are assumed one cycle wide. A held-high input is acted on every cycle, so add_* would repeat.
- Reset mid-COOK: outputs go to their reset values asynchronously, without waiting for a clock edge.

## Test plan

All scenarios use CLK_HZ=10, BEEP_SEC=3.

- **Add then cook to completion:** reset, add_10s_p, start_p.
  - Expect SET with time_left=10, then COOK.
  - time_left decrements every 10 cycles.
  - DONE with beep=1 exactly 100 cycles after COOK entry.
  - IDLE 30 cycles after that.
- **Door during cook:** COOK with time_left=5, door_open=1.
  - Expect PAUSE next cycle, magnetron_on=0, lamp_on=1, time_left=5.
  - start_p with the door open is ignored.
  - Close the door, then start_p: COOK, and the next decrement comes 10 cycles later.
- **Saturation:** 100 add_min_p pulses.
  - Expect time_left=5999 and no wrap.
  - add_10s_p leaves it at 5999.
- **Same-cycle events:**
  - stop_p+start_p in SET: expect IDLE, time_left=0.
  - add_10s_p on a tick cycle in COOK with time_left=7: expect 16.
- **Quick start and cancel:**
  - start_p in IDLE: expect COOK with time_left=30.
  - stop_p: PAUSE.
  - stop_p again: IDLE with time_left=0.
- **Async reset mid-operation:** assert rst_n=0 mid-cycle in COOK.
  - Expect state=0, time_left=0, magnetron_on=0 before the next clock edge.
